// File: rtl/input_fetch_if.sv
// input_fetch_if: bundles the fetch request, the SRAM read channel and the
// block result of input_fetch.
//   fetch_start/start_addr/block_addr : block fetch request (into the fetcher)
//   rd_en/rd_addr                     : single-byte SRAM read request (out)
//   rd_data/rd_valid                  : SRAM read response (in)
//   data_o/busy/fetch_done            : assembled 4x4 block and status (out)
// master = the fetch engine, slave = the requester / SRAM side.
interface input_fetch_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned PIX_W  = 8;
    localparam int unsigned DIM    = 4;

    logic                                   fetch_start;
    logic [ADDR_W-1:0]                      start_addr;
    logic [ADDR_W-1:0]                      block_addr;
    logic                                   rd_en;
    logic [ADDR_W-1:0]                      rd_addr;
    logic [PIX_W-1:0]                       rd_data;
    logic                                   rd_valid;
    logic [DIM-1:0][DIM-1:0][PIX_W-1:0]     data_o;
    logic                                   busy;
    logic                                   fetch_done;

    modport master (
        input  fetch_start, start_addr, block_addr, rd_data, rd_valid,
        output rd_en, rd_addr, data_o, busy, fetch_done
    );

    modport slave (
        output fetch_start, start_addr, block_addr, rd_data, rd_valid,
        input  rd_en, rd_addr, data_o, busy, fetch_done
    );
endinterface

// File: rtl/input_fetch.sv
// input_fetch: reads one 4x4 block of 8-bit pixels from SRAM, one byte per
// request, with at most one read outstanding. Pixels are fetched row-major
// from base + row*ROW_STRIDE + col and stored into data_o[row][col];
// fetch_done pulses for one cycle once all 16 are stored.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : input_fetch_if.master (request, SRAM read channel, block result)
module input_fetch #(
    parameter logic [31:0] ROW_STRIDE  = 32'd400,
    parameter logic [31:0] BASE_OFFSET = 32'd0
) (
    input  logic          clk,
    input  logic          rst,
    input_fetch_if.master bus
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned PIX_W  = 8;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned DIM    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e                             state_q, state_d;
    logic [IDX_W-1:0]                   idx_q, idx_d;
    logic [ADDR_W-1:0]                  base_q, base_d;
    logic                               rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]                  rd_addr_q, rd_addr_d;
    logic                               busy_q, busy_d;
    logic                               done_q, done_d;
    logic [DIM-1:0][DIM-1:0][PIX_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0]                  row_off;
    logic [ADDR_W-1:0]                  col_off;

    // Next state, pixel index, block base and captured pixel data.
    // Outputs are derived from the next state so they register as Moore
    // outputs of the state they belong to.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        base_d    = base_q;
        data_d    = data_q;
        rd_addr_d = rd_addr_q;
        row_off   = '0;
        col_off   = '0;

        case (state_q)
            IDLE: begin
                if (bus.fetch_start) begin
                    base_d  = ADDR_W'(bus.start_addr + bus.block_addr + BASE_OFFSET);
                    data_d  = '0;
                    idx_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Responses in any other state are dropped by construction.
                if (bus.rd_valid) begin
                    data_d[idx_q[3:2]][idx_q[1:0]] = bus.rd_data;
                    if (idx_q == IDX_W'(15)) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = IDX_W'(idx_q + IDX_W'(1));
                        state_d = REQ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Address of the pixel about to be requested; wraps modulo 2^32.
        if (state_d == REQ) begin
            row_off   = ADDR_W'(ADDR_W'(idx_d[3:2]) * ROW_STRIDE);
            col_off   = ADDR_W'(idx_d[1:0]);
            rd_addr_d = ADDR_W'(base_d + row_off + col_off);
        end

        rd_en_d = (state_d == REQ);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            base_q    <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            base_q    <= base_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            data_q    <= data_d;
        end
    end

    assign bus.rd_en      = rd_en_q;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.busy       = busy_q;
    assign bus.fetch_done = done_q;
    assign bus.data_o     = data_q;
endmodule
